mips16_fetch_decode: RTL and testbench
======================================

// Module: mips16_fetch_decode
// PURPOSE
//  Fetch/decode stage directly upstream of the MIPS16 execute/PC datapath. Fetches a 16-bit
//  instruction at the datapath's pc_out, decodes opcode/Function, reads operands from an 8x16
//  register file and computes branch target L and jump target LJ. Hands results over a
//  valid/ready handshake; also owns the register-file writeback port.
// PARAMETERS
//  RESET_PC        16'h0000  fetch address used when the stage leaves reset
//  TIMEOUT_CYCLES  15        cycles in S_REQ without imem_ack before fetch_err (range 2..255)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  fetch_en     in   1   permit new fetches
//  pc_in        in   16  fetch address (datapath pc_out); bit0 ignored
//  imem_req     out  1   instruction memory request, held until imem_ack
//  imem_addr    out  16  registered fetch address {pc[15:1],1'b0}
//  imem_ack     in   1   memory returns imem_rdata this cycle
//  imem_rdata   in   16  instruction word
//  wb_en        in   1   register-file write enable
//  wb_addr      in   3   write register; r0 writes discarded
//  wb_data      in   16  write data
//  dec_valid    out  1   decoded outputs valid
//  dec_ready    in   1   downstream consumes decoded bundle
//  opcode       out  3   instr[15:13]
//  Function     out  4   instr[3:0]
//  reg1         out  16  R[instr[12:10]]
//  reg2         out  16  R[instr[9:7]]
//  L            out  16  pc+2 + (sext(instr[6:0])<<1), mod 2^16
//  LJ           out  16  {pc_plus2[15:14], instr[12:0], 1'b0}
//  fetch_err    out  1   one-cycle pulse on fetch timeout
// BEHAVIOUR
//  Reset (async): state S_IDLE; all outputs, IR, timeout counter, r1..r7 = 0; imem_addr=RESET_PC.
//  r0 reads as 0 always. Writes at rising edge when wb_en && wb_addr!=0.
//  FSM:
//   S_IDLE : imem_req=0. fetch_en=1 -> latch pc_in into imem_addr (first fetch after reset
//            uses RESET_PC), clear counter, go S_REQ.
//   S_REQ  : imem_req=1, imem_addr stable. imem_ack -> capture IR, opcode/Function, reg1/reg2,
//            L, LJ from imem_rdata in same edge; go S_VALID. No ack and counter==TIMEOUT_CYCLES-1
//            -> fetch_err=1 for one cycle, counter=0, stay S_REQ (request re-issued, same addr).
//   S_VALID: dec_valid=1; outputs held stable. dec_ready -> if fetch_en: latch pc_in, go S_REQ;
//            else go S_IDLE. dec_valid falls the cycle after handshake.
//  Latency: imem_ack edge -> dec_valid high next cycle; back-to-back minimum 2 cycles/instr
//   (REQ with immediate ack, VALID with dec_ready).
//  Hazard refresh: in S_VALID a write to a register sourced by reg1/reg2 updates that output
//   at the same edge (dec_valid stays 1). r0 never refreshed.
//  dec_ready ignored outside S_VALID; imem_ack ignored outside S_REQ.
//  fetch_en deasserted in S_REQ: request completes; S_VALID then exits to S_IDLE.
//  Arithmetic: all 16-bit, wrap-around silently (pc 16'hFFFE -> pc+2 = 0).
//  Reset mid-fetch: imem_req drops immediately (async); pending ack discarded.
// CONFIGURATION
//  FORWARD_WB_EN defined: at S_REQ capture, a same-cycle write (wb_en, wb_addr matching rs/rt,
//   !=0) is bypassed so reg1/reg2 carry wb_data.
//  FORWARD_WB_EN undefined: capture uses pre-write register contents; new value visible only via
//   S_VALID refresh or next fetch.
// TESTING
//  Reset, fetch_en=1, pc_in=16'h0040, ack after 1 cycle with 16'h0000 -> imem_addr=RESET_PC first,
//   dec_valid 1 cycle after ack, opcode=0, reg1=reg2=0.
//  Write r2=16'h1234,r3=16'h0005; fetch 16'b000_010_011_000_0000 at pc 16'h0010 -> reg1=16'h1234,
//   reg2=16'h0005, L=16'h0012, Function=0.
//  Fetch imm7=7'h7F at pc 16'h0010 -> L=16'h0010; pc 16'hFFFE, imm 0 -> L=16'h0000;
//   jump target 13'h0155 at pc 16'h4000 -> LJ=16'h42AA.
//  Withhold imem_ack 15 cycles -> fetch_err pulse at cycle 15, imem_req stays 1, addr unchanged;
//   ack at cycle 20 -> normal decode.
//  Hold dec_ready=0 in S_VALID, write r2=16'hBEEF -> reg1 becomes 16'hBEEF next edge, others
//   stable; wb_addr=0 write -> no change, r0 reads 0.
//  Same-cycle wb to rs at ack: with FORWARD_WB_EN reg1=wb_data, without reg1=old value;
//   rst_n low during S_REQ -> imem_req=0, dec_valid=0 immediately.

Source files
------------

// File: rtl/mips16_fetch_decode_if.sv
// Fetch/decode bus bundle: instruction-memory request/ack plus the decoded-output valid/ready handshake.
// master = fetch/decode stage, slave = instruction memory and downstream execute stage.
interface mips16_fetch_decode_if;
  // Handshakes: imem_req stays high until a cycle with imem_ack (data taken that cycle);
  // the decoded bundle transfers on a cycle where dec_valid && dec_ready, and it is held stable while dec_valid is high.
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  opcode;
  logic [3:0]  Function;
  logic [15:0] reg1;
  logic [15:0] reg2;
  logic [15:0] L;
  logic [15:0] LJ;

  modport master (
    output imem_req, imem_addr, dec_valid, opcode, Function, reg1, reg2, L, LJ,
    input  imem_ack, imem_rdata, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, opcode, Function, reg1, reg2, L, LJ,
    output imem_ack, imem_rdata, dec_ready
  );
endinterface

// File: rtl/mips16_fetch_decode.sv
// MIPS16 fetch/decode stage: fetches, decodes, and reads operands from an 8x16 register file.
// Optional macro FORWARD_WB_EN bypasses a same-cycle writeback into reg1/reg2 at instruction capture.
module mips16_fetch_decode #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_en,
    input  logic [15:0]               pc_in,
    input  logic                      wb_en,
    input  logic [2:0]                wb_addr,
    input  logic [15:0]               wb_data,
    mips16_fetch_decode_if.master     bus,
    output logic                      fetch_err,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_VALID = 2'd2} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        first;
    logic [2:0]  ir_rs;
    logic [2:0]  ir_rt;
    logic [15:0] rf [0:7];

    logic [2:0]  cap_rs;
    logic [2:0]  cap_rt;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] pc_plus2;
    logic [15:0] imm_off;
    logic [15:0] next_addr;
    logic        wb_live;

    assign state_dbg = state;
    assign cap_rs    = bus.imem_rdata[12:10];
    assign cap_rt    = bus.imem_rdata[9:7];
    assign pc_plus2  = bus.imem_addr + 16'd2;
    assign imm_off   = {{8{bus.imem_rdata[6]}}, bus.imem_rdata[6:0], 1'b0};
    assign next_addr = pc_in & 16'hFFFE;
    assign wb_live   = wb_en && (wb_addr != 3'd0);

    // rf[0] is never written, so r0 always reads as zero.
    always_comb begin
        rd1 = rf[cap_rs];
        rd2 = rf[cap_rt];
`ifdef FORWARD_WB_EN
        if (wb_live && (wb_addr == cap_rs)) rd1 = wb_data;
        if (wb_live && (wb_addr == cap_rt)) rd2 = wb_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (wb_live) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            first         <= 1'b1;
            ir_rs         <= 3'd0;
            ir_rt         <= 3'd0;
            fetch_err     <= 1'b0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC & 16'hFFFE;
            bus.dec_valid <= 1'b0;
            bus.opcode    <= 3'd0;
            bus.Function  <= 4'd0;
            bus.reg1      <= 16'h0000;
            bus.reg2      <= 16'h0000;
            bus.L         <= 16'h0000;
            bus.LJ        <= 16'h0000;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch_en) begin
                        bus.imem_addr <= first ? (RESET_PC & 16'hFFFE) : next_addr;
                        first         <= 1'b0;
                        cnt           <= 8'd0;
                        bus.imem_req  <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        ir_rs         <= cap_rs;
                        ir_rt         <= cap_rt;
                        bus.opcode    <= bus.imem_rdata[15:13];
                        bus.Function  <= bus.imem_rdata[3:0];
                        bus.reg1      <= rd1;
                        bus.reg2      <= rd2;
                        bus.L         <= pc_plus2 + imm_off;
                        bus.LJ        <= {pc_plus2[15:14], bus.imem_rdata[12:0], 1'b0};
                        bus.imem_req  <= 1'b0;
                        bus.dec_valid <= 1'b1;
                        state         <= S_VALID;
                    end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        // Timeout only flags the stall; the request stays up at the same address.
                        fetch_err <= 1'b1;
                        cnt       <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_VALID: begin
                    // Keep the held operands coherent with writebacks landing while we wait.
                    if (wb_live && (wb_addr == ir_rs)) bus.reg1 <= wb_data;
                    if (wb_live && (wb_addr == ir_rt)) bus.reg2 <= wb_data;
                    if (bus.dec_ready) begin
                        bus.dec_valid <= 1'b0;
                        if (fetch_en) begin
                            bus.imem_addr <= next_addr;
                            cnt           <= 8'd0;
                            bus.imem_req  <= 1'b1;
                            state         <= S_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    bus.imem_req  <= 1'b0;
                    bus.dec_valid <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips16_fetch_decode.sv
// Self-checking bench for mips16_fetch_decode: directed cases followed by randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mips16_fetch_decode;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 15;

  // ---------------- clock / reset ----------------
  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        fetch_en = 1'b0;
  logic [15:0] pc_in    = 16'h0000;
  logic        wb_en    = 1'b0;
  logic [2:0]  wb_addr  = 3'd0;
  logic [15:0] wb_data  = 16'h0000;
  logic        fetch_err;
  logic [1:0]  state_dbg;

  mips16_fetch_decode_if bus ();

  mips16_fetch_decode #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .pc_in     (pc_in),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .bus       (bus),
    .fetch_err (fetch_err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [70:0] exp_q[$];
  logic [15:0] m_regs [8];
  int          m_ph;        // 0 idle, 1 request outstanding, 2 bundle offered
  bit          m_first;
  logic [15:0] m_addr;
  int          m_wait;      // cycles waited since request issue or last timeout
  bit          m_err;
  logic [2:0]  m_rs;
  logic [2:0]  m_rt;
  int          waited;
  int          ack_after;

  task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [70:0] decode(input logic [15:0] instr, input logic [15:0] pc,
                                         input logic [15:0] a, input logic [15:0] b);
    int          imm;
    logic [15:0] p2;
    logic [15:0] l;
    logic [15:0] lj;
    imm = int'(instr & 16'h007F);
    if (imm >= 64) imm -= 128;
    p2 = pc + 16'd2;
    l  = 16'(int'(p2) + 2 * imm);
    lj = (p2 & 16'hC000) | ((instr & 16'h1FFF) << 1);
    return {3'(instr >> 13), 4'(instr & 16'h000F), a, b, l, lj};
  endfunction

  function automatic logic [70:0] observed();
    return {bus.opcode, bus.Function, bus.reg1, bus.reg2, bus.L, bus.LJ};
  endfunction

  task automatic model_reset();
    m_ph    = 0;
    m_first = 1'b1;
    m_addr  = RESET_PC & 16'hFFFE;
    m_wait  = 0;
    m_err   = 1'b0;
    exp_q.delete();
    foreach (m_regs[i]) m_regs[i] = 16'h0000;
  endtask

  task automatic issue(input logic [15:0] addr);
    m_addr    = addr;
    m_wait    = 0;
    m_ph      = 1;
    waited    = 0;
    ack_after = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 32) : $urandom_range(0, 2);
  endtask

  // Compare the current cycle, then apply the driven inputs to the model and advance one clock.
  task automatic step();
    logic [70:0] t;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rs;
    logic [2:0]  rt;
    bit          nerr;
    check("imem_req", bus.imem_req, m_ph == 1);
    check("dec_valid", bus.dec_valid, m_ph == 2);
    check("fetch_err", fetch_err, m_err);
    check("imem_addr", bus.imem_addr, m_addr);
    if (m_ph == 2 && exp_q.size() > 0) check("bundle", observed(), exp_q[0]);
    nerr = 1'b0;
    case (m_ph)
      0: if (fetch_en) begin
        issue(m_first ? (RESET_PC & 16'hFFFE) : (pc_in & 16'hFFFE));
        m_first = 1'b0;
      end
      1: if (bus.imem_ack) begin
        rs = 3'(bus.imem_rdata >> 10);
        rt = 3'(bus.imem_rdata >> 7);
        a  = m_regs[rs];
        b  = m_regs[rt];
`ifdef FORWARD_WB_EN
        if (wb_en && wb_addr != 0 && wb_addr == rs) a = wb_data;
        if (wb_en && wb_addr != 0 && wb_addr == rt) b = wb_data;
`endif
        exp_q.push_back(decode(bus.imem_rdata, m_addr, a, b));
        m_rs = rs;
        m_rt = rt;
        m_ph = 2;
      end else begin
        waited++;
        if (m_wait == TIMEOUT - 1) begin
          nerr   = 1'b1;
          m_wait = 0;
        end else begin
          m_wait++;
        end
      end
      default: begin
        if (wb_en && wb_addr != 0 && exp_q.size() > 0) begin
          t = exp_q[0];
          if (wb_addr == m_rs) t[63:48] = wb_data;
          if (wb_addr == m_rt) t[47:32] = wb_data;
          exp_q[0] = t;
        end
        if (bus.dec_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (fetch_en) issue(pc_in & 16'hFFFE);
          else m_ph = 0;
        end
      end
    endcase
    m_err = nerr;
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic fetch_directed(input logic [15:0] pc, input logic [15:0] instr);
    fetch_en = 1'b1;
    pc_in    = pc;
    step();
    fetch_en       = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = instr;
    step();
    bus.imem_ack = 1'b0;
  endtask

  task automatic handshake();
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready = 1'b0;
    check("hs_valid_low", bus.dec_valid, 1'b0);
  endtask

  task automatic write_reg(input logic [2:0] r, input logic [15:0] d);
    wb_en   = 1'b1;
    wb_addr = r;
    wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_valid;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dec_ready  = 1'b0;
    waited         = 0;
    ack_after      = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_valid", bus.dec_valid, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    check("rst_addr", bus.imem_addr, RESET_PC);
    check("rst_bundle", observed(), 71'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First fetch after reset ignores pc_in and uses RESET_PC; ack after one cycle.
    fetch_en = 1'b1;
    pc_in    = 16'h0040;
    step();
    fetch_en = 1'b0;
    check("t1_addr", bus.imem_addr, RESET_PC);
    step();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h0000;
    step();
    bus.imem_ack = 1'b0;
    check("t1_valid", bus.dec_valid, 1'b1);
    check("t1_opcode", bus.opcode, 3'd0);
    check("t1_reg1", bus.reg1, 16'h0000);
    check("t1_reg2", bus.reg2, 16'h0000);
    handshake();

    // Register operands and branch target.
    write_reg(3'd2, 16'h1234);
    write_reg(3'd3, 16'h0005);
    fetch_directed(16'h0010, 16'h0980);
    check("t2_reg1", bus.reg1, 16'h1234);
    check("t2_reg2", bus.reg2, 16'h0005);
    check("t2_L", bus.L, 16'h0012);
    check("t2_func", bus.Function, 4'd0);
    handshake();

    // Negative offset, PC wrap, jump target.
    fetch_directed(16'h0010, 16'h007F);
    check("t3_L_neg", bus.L, 16'h0010);
    handshake();
    fetch_directed(16'hFFFE, 16'h0000);
    check("t3_L_wrap", bus.L, 16'h0000);
    handshake();
    fetch_directed(16'h4000, 16'h0155);
    check("t3_LJ", bus.LJ, 16'h42AA);
    handshake();

    // Withheld ack: timeout pulse after 15 cycles, request held; ack on cycle 20.
    fetch_en = 1'b1;
    pc_in    = 16'h0100;
    step();
    fetch_en = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step();
      check("to_err", fetch_err, k == 15);
      check("to_req", bus.imem_req, 1'b1);
      check("to_addr", bus.imem_addr, 16'h0100);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h0980;
    step();
    bus.imem_ack = 1'b0;
    check("to_valid", bus.dec_valid, 1'b1);
    check("to_reg1", bus.reg1, 16'h1234);
    handshake();

    // Writeback refresh while the bundle is held; r0 writes are dropped.
    fetch_directed(16'h0020, 16'h0980);
    write_reg(3'd2, 16'hBEEF);
    check("rf_reg1", bus.reg1, 16'hBEEF);
    check("rf_reg2", bus.reg2, 16'h0005);
    check("rf_valid", bus.dec_valid, 1'b1);
    write_reg(3'd0, 16'hFFFF);
    check("rf_r0_reg1", bus.reg1, 16'hBEEF);
    check("rf_r0_reg2", bus.reg2, 16'h0005);
    handshake();
    fetch_directed(16'h0030, 16'h0180);
    check("r0_read", bus.reg1, 16'h0000);
    handshake();

    // Writeback to rs in the same cycle as the ack.
    fetch_en = 1'b1;
    pc_in    = 16'h0040;
    step();
    fetch_en       = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h0980;
    wb_en          = 1'b1;
    wb_addr        = 3'd2;
    wb_data        = 16'h5555;
    step();
    bus.imem_ack = 1'b0;
    wb_en        = 1'b0;
`ifdef FORWARD_WB_EN
    check("same_cycle_wb", bus.reg1, 16'h5555);
`else
    check("same_cycle_wb", bus.reg1, 16'hBEEF);
`endif
    handshake();

    // Back-to-back: two cycles per instruction with ack and ready always high.
    fetch_en      = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.dec_ready = 1'b1;
    n_valid       = 0;
    for (int k = 0; k < 10; k++) begin
      pc_in          = 16'($urandom);
      bus.imem_rdata = 16'($urandom);
      step();
      if (bus.dec_valid) n_valid++;
    end
    check("b2b_count", n_valid, 5);
    fetch_en     = 1'b0;
    bus.imem_ack = 1'b0;
    step();
    bus.dec_ready = 1'b0;

    // Reset while a request is outstanding drops outputs immediately.
    fetch_en = 1'b1;
    pc_in    = 16'h0050;
    step();
    fetch_en = 1'b0;
    check("mr_req_before", bus.imem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_req", bus.imem_req, 1'b0);
    check("mr_valid", bus.dec_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic, acks and readies also toggled when they must be ignored.
    for (int c = 0; c < 2500; c++) begin
      fetch_en       = ($urandom_range(0, 7) != 0);
      pc_in          = 16'($urandom);
      wb_en          = 1'($urandom_range(0, 1));
      wb_addr        = 3'($urandom_range(0, 7));
      wb_data        = 16'($urandom);
      bus.imem_ack   = (m_ph == 1) ? (waited >= ack_after) : 1'($urandom_range(0, 1));
      bus.imem_rdata = 16'($urandom);
      bus.dec_ready  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
